// File: rtl/button_pkg.sv
// Shared constants for the push-button event controller: bus addresses,
// legacy level-read codes and the one-hot level decode.
package button_pkg;

  localparam int NUM_BTN = 5;

  localparam logic [31:0] BTN_LEVEL_ADDR = 32'hFFFF_F078;
  localparam logic [31:0] BTN_EVENT_ADDR = 32'hFFFF_F07C;
  localparam logic [31:0] BTN_IRQEN_ADDR = 32'hFFFF_F080;

  localparam logic [31:0] LEVEL_S0   = 32'h1111_1111;
  localparam logic [31:0] LEVEL_S1   = 32'h2222_2222;
  localparam logic [31:0] LEVEL_S2   = 32'h4444_4444;
  localparam logic [31:0] LEVEL_S3   = 32'h8888_8888;
  localparam logic [31:0] LEVEL_S4   = 32'hFFFF_FFFF;
  localparam logic [31:0] LEVEL_NONE = 32'h0000_0000;

  // Only a single pressed button has a legacy code; chords read as none.
  function automatic logic [31:0] level_code(input logic [NUM_BTN-1:0] level);
    case (level)
      5'b00001: level_code = LEVEL_S0;
      5'b00010: level_code = LEVEL_S1;
      5'b00100: level_code = LEVEL_S2;
      5'b01000: level_code = LEVEL_S3;
      5'b10000: level_code = LEVEL_S4;
      default:  level_code = LEVEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One button bit: 2-flop synchroniser, stable-sample counter and debounced
// level. rise is high in the cycle whose edge will take level 0->1.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W           = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  assign rise = s2 & ~level & (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      // Any sample that agrees with level restarts the stability run.
      if (s2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= s2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/button_event_ctrl.sv
// MMIO push-button controller: debounced levels with legacy encoding, sticky
// W1C press events, per-button interrupt enables and a registered level irq.
module button_event_ctrl
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W           = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        addr,
  input  logic               we,
  input  logic [31:0]        wdata,
  input  logic [NUM_BTN-1:0] button,
  output logic [31:0]        rdata,
  output logic               irq
);

  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] event_q;
  logic [NUM_BTN-1:0] irqen_q;
  logic [NUM_BTN-1:0] event_clr;
  logic [NUM_BTN-1:0] event_next;
  logic [NUM_BTN-1:0] irqen_next;
  logic               unused_wdata;

  assign unused_wdata = ^wdata[31:NUM_BTN];

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .raw  (button[i]),
      .level(level[i]),
      .rise (rise[i])
    );
  end

  // A press landing on the same edge as its W1C wins over the clear.
  always_comb begin
    event_clr  = '0;
    irqen_next = irqen_q;
    if (we && (addr == BTN_EVENT_ADDR)) event_clr  = wdata[NUM_BTN-1:0];
    if (we && (addr == BTN_IRQEN_ADDR)) irqen_next = wdata[NUM_BTN-1:0];
    event_next = (event_q & ~event_clr) | rise;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      event_q <= '0;
      irqen_q <= '0;
      irq     <= 1'b0;
    end else begin
      event_q <= event_next;
      irqen_q <= irqen_next;
      irq     <= |(event_next & irqen_next);
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      BTN_LEVEL_ADDR: rdata = level_code(level);
      BTN_EVENT_ADDR: rdata = {{(32-NUM_BTN){1'b0}}, event_q};
      BTN_IRQEN_ADDR: rdata = {{(32-NUM_BTN){1'b0}}, irqen_q};
      default:        rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed plus randomized bench for button_event_ctrl against a sample-window
// reference model of the debounce, event and interrupt rules.
module tb_button_event_ctrl;
  import button_pkg::*;

  localparam int DC = 4;
  localparam logic [31:0] BAD_ADDR = 32'hFFFF_F084;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [4:0]  button;
  logic [31:0] rdata;
  logic        irq;

  int total = 0;
  int bad   = 0;

  // reference model: hist[0] is the newest raw sample taken at a clock edge
  logic [4:0] hist[$];
  logic [4:0] m_level, m_ev, m_en;
  logic       m_irq;

  button_event_ctrl #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .addr(addr), .we(we), .wdata(wdata),
    .button(button), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] exp_level(input logic [4:0] l);
    case (l)
      5'b00001: return 32'h1111_1111;
      5'b00010: return 32'h2222_2222;
      5'b00100: return 32'h4444_4444;
      5'b01000: return 32'h8888_8888;
      5'b10000: return 32'hFFFF_FFFF;
      default:  return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_level = '0; m_ev = '0; m_en = '0; m_irq = 1'b0;
    hist.delete();
    for (int k = 0; k < DC + 2; k++) hist.push_back(5'b0);
  endtask

  // A bit flips once the DC synchronised samples seen at this edge
  // (raw samples two to DC+1 edges old) all disagree with it.
  task automatic model_edge(input logic [4:0] b, input logic w,
                            input logic [31:0] a, input logic [31:0] d);
    logic [4:0] rs, clr;
    logic       all_diff;
    hist.push_front(b);
    rs = '0;
    for (int i = 0; i < 5; i++) begin
      all_diff = 1'b1;
      for (int k = 2; k <= DC + 1; k++)
        if (hist[k][i] == m_level[i]) all_diff = 1'b0;
      if (all_diff) begin
        if (!m_level[i]) rs[i] = 1'b1;
        m_level[i] = ~m_level[i];
      end
    end
    while (hist.size() > DC + 2) void'(hist.pop_back());
    clr = (w && a == BTN_EVENT_ADDR) ? d[4:0] : 5'b0;
    m_ev = (m_ev & ~clr) | rs;
    if (w && a == BTN_IRQEN_ADDR) m_en = d[4:0];
    m_irq = |(m_ev & m_en);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] v;
    rd(BTN_LEVEL_ADDR, v); chk({tag, ".level"}, v, exp_level(m_level));
    rd(BTN_EVENT_ADDR, v); chk({tag, ".event"}, v, {27'b0, m_ev});
    rd(BTN_IRQEN_ADDR, v); chk({tag, ".irqen"}, v, {27'b0, m_en});
    rd(BAD_ADDR, v);       chk({tag, ".other"}, v, 32'h0);
    chk({tag, ".irq"}, {31'b0, irq}, {31'b0, m_irq});
  endtask

  task automatic step(input string tag, input logic [4:0] b, input logic w,
                      input logic [31:0] a, input logic [31:0] d);
    button = b; we = w; addr = a; wdata = d;
    @(posedge clk);
    model_edge(b, w, a, d);
    #1;
    we = 1'b0;
    check_all(tag);
  endtask

  task automatic hold(input string tag, input logic [4:0] b, input int n);
    for (int k = 0; k < n; k++) step(tag, b, 1'b0, BTN_LEVEL_ADDR, 32'h0);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    chk(tag, v, exp);
  endtask

  initial begin
    logic [4:0]  b;
    logic [31:0] a;
    logic [31:0] addrs[5];
    addrs[0] = BTN_LEVEL_ADDR; addrs[1] = BTN_EVENT_ADDR; addrs[2] = BTN_IRQEN_ADDR;
    addrs[3] = BAD_ADDR;       addrs[4] = 32'h0000_0000;

    rst = 1'b0; addr = '0; we = 1'b0; wdata = '0; button = '0;
    model_reset();
    #2;
    check_all("in_reset");
    #10 rst = 1'b1;

    // clean press of S0: visible after edge 5, not edge 4
    hold("press_s0", 5'b00001, 5);
    rd_chk("s0_edge4_level", BTN_LEVEL_ADDR, 32'h0);
    hold("press_s0", 5'b00001, 1);
    rd_chk("s0_edge5_level", BTN_LEVEL_ADDR, 32'h1111_1111);
    rd_chk("s0_edge5_event", BTN_EVENT_ADDR, 32'h1);
    hold("release_s0", 5'b00000, 7);

    // bounce on S2 shorter than the debounce window
    step("clear_all", 5'b00000, 1'b1, BTN_EVENT_ADDR, 32'hFFFF_FFFF);
    for (int c = 0; c < 20; c++) hold("bounce", ((c / 2) % 2) ? 5'b00100 : 5'b00000, 1);
    hold("bounce_quiet", 5'b00000, 6);
    rd_chk("bounce_level", BTN_LEVEL_ADDR, 32'h0);
    rd_chk("bounce_event", BTN_EVENT_ADDR, 32'h0);
    chk("bounce_irq", {31'b0, irq}, 32'h0);

    // interrupt flow on S3
    step("irqen_wr", 5'b00000, 1'b1, BTN_IRQEN_ADDR, 32'hFFFF_FF08);
    hold("press_s3", 5'b01000, 6);
    rd_chk("s3_event", BTN_EVENT_ADDR, 32'h8);
    hold("press_s3_hold", 5'b01000, 1);
    chk("s3_irq", {31'b0, irq}, 32'h1);
    step("w1c_s3", 5'b01000, 1'b1, BTN_EVENT_ADDR, 32'h0000_0008);
    rd_chk("s3_cleared", BTN_EVENT_ADDR, 32'h0);
    chk("s3_irq_low", {31'b0, irq}, 32'h0);
    hold("release_s3", 5'b00000, 8);
    rd_chk("s3_release_event", BTN_EVENT_ADDR, 32'h0);

    // W1C on the very edge S4's level rises
    hold("press_s4", 5'b10000, 5);
    step("s4_w1c_race", 5'b10000, 1'b1, BTN_EVENT_ADDR, 32'h0000_0010);
    rd_chk("race_event", BTN_EVENT_ADDR, 32'h10);
    rd_chk("race_level", BTN_LEVEL_ADDR, 32'hFFFF_FFFF);
    step("clear_all", 5'b00000, 1'b1, BTN_EVENT_ADDR, 32'h1F);
    hold("release_s4", 5'b00000, 7);

    // two buttons together, then an unmapped address
    hold("multi", 5'b00011, 6);
    rd_chk("multi_level", BTN_LEVEL_ADDR, 32'h0);
    rd_chk("multi_event", BTN_EVENT_ADDR, 32'h3);
    step("bad_wr", 5'b00011, 1'b1, BAD_ADDR, 32'hFFFF_FFFF);
    rd_chk("bad_rd", BAD_ADDR, 32'h0);
    rd_chk("bad_wr_event", BTN_EVENT_ADDR, 32'h3);
    rd_chk("bad_wr_irqen", BTN_IRQEN_ADDR, 32'h8);
    step("level_wr", 5'b00011, 1'b1, BTN_LEVEL_ADDR, 32'hFFFF_FFFF);
    step("clear_all", 5'b00000, 1'b1, BTN_EVENT_ADDR, 32'h1F);
    hold("release_multi", 5'b00000, 7);

    // randomized buttons and bus traffic
    for (int r = 0; r < 40; r++) begin
      b = 5'($urandom);
      if ($urandom_range(0, 2) == 0) b = 5'b00001 << $urandom_range(0, 4);
      for (int k = 0; k < int'($urandom_range(1, 8)); k++) begin
        if ($urandom_range(0, 3) == 0) begin
          a = addrs[$urandom_range(0, 4)];
          step("rand_wr", b, 1'b1, a, $urandom);
        end else begin
          hold("rand", b, 1);
        end
      end
    end

    // reset in the middle of an S2 debounce run
    step("clear_all", 5'b00000, 1'b1, BTN_EVENT_ADDR, 32'h1F);
    step("irqen_all", 5'b00000, 1'b1, BTN_IRQEN_ADDR, 32'h1F);
    hold("pre_rst_quiet", 5'b00000, 7);
    hold("pre_rst_s2", 5'b00100, 4);
    rst = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b1;
    hold("post_rst_s2", 5'b00100, 5);
    rd_chk("post_rst_early", BTN_LEVEL_ADDR, 32'h0);
    hold("post_rst_s2", 5'b00100, 1);
    rd_chk("post_rst_level", BTN_LEVEL_ADDR, 32'h4444_4444);
    rd_chk("post_rst_event", BTN_EVENT_ADDR, 32'h4);
    chk("post_rst_irq", {31'b0, irq}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
